serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial two-operand adder built around a single one-bit full-add slice plus a carry flip-flop.
- Accepts two WIDTH-bit operands over a valid/ready handshake and adds them LSB-first, one bit per clock.
- Presents the WIDTH-bit sum and final carry over a second valid/ready handshake.
- It is the sequencing stage around a one-bit adder: multi-bit addition built from one-bit hardware over time.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  sum/carry_out hold a completed result.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  WIDTH  (a + b) mod 2^WIDTH.
- carry_out  output  1  bit WIDTH of a + b.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - On reset the FSM goes to IDLE and all registers clear: out_valid=0, sum=0, carry_out=0, carry=0, count=0.
  - in_ready is combinational: 1 when state==IDLE and rst==0.
- States are IDLE, ADD, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Operands are accepted on an edge where in_valid && in_ready. On that edge, a_sh<=a, b_sh<=b, carry<=0, count<=0, and the FSM moves to ADD.
  - a and b are ignored at all other times.
- ADD:
  - in_ready=0, out_valid=0.
  - Each edge computes s = a_sh[0]^b_sh[0]^carry and c = majority(a_sh[0], b_sh[0], carry).
  - On the same edge: a_sh and b_sh shift right by 1; s is shifted into the sum register at the MSB while the register shifts right; carry<=c; count<=count+1.
  - On the edge where count==WIDTH-1 (the WIDTH-th ADD edge), carry_out<=c and the FSM moves to DONE.
- DONE:
  - out_valid=1. sum and carry_out are held stable while out_ready=0.
  - On out_valid && out_ready the FSM returns to IDLE and out_valid falls on that same edge.
  - No same-cycle re-accept: in_ready only rises in the cycle after the result is taken.
- Latency and throughput:
  - The handshake edge is T0; out_valid is first high in the cycle after edge T0+WIDTH.
  - Minimum spacing between accepted operations is WIDTH+2 cycles.
- Output validity:
  - sum changes during ADD. sum and carry_out are only meaningful while out_valid=1, and the bench must check them only then.
- Widths:
  - count is $clog2(WIDTH+1) bits.
  - All arithmetic is unsigned; no overflow flag beyond carry_out.
- Boundary conditions:
  - WIDTH=1: exactly one ADD cycle.
  - Wrap-around: e.g. all-ones + 1 gives sum=0, carry_out=1.
  - rst in any state, including mid-ADD or DONE with out_ready=0: the operation is discarded, no out_valid pulse is produced, and in_ready=1 from the first cycle after rst deasserts.
  - in_valid held high while busy has no effect; the operands are not queued.
  - out_ready high while not out_valid is ignored.

Decomposition:
- Package serial_adder_pkg holds:
  - the state enum (IDLE, ADD, DONE), 2 bits;
  - a localparam function or macro for the counter width.
- Sub-module full_adder_bit is a natural split: combinational inputs a, b, cin and outputs s, cout. It is instantiated once and carries the one-bit add.
- serial_adder holds the FSM, shift registers, counter and carry register.

Test Plan:
- WIDTH=8, a=3, b=5, out_ready=1 → out_valid rises 9 cycles after the accept cycle; sum=8, carry_out=0; in_ready=0 for the whole operation.
- WIDTH=8, a=200, b=100 → sum=44, carry_out=1. Then a=255, b=1 → sum=0, carry_out=1. Then a=255, b=255 → sum=254, carry_out=1.
- WIDTH=8, a=7, b=9, with out_ready held 0 for 5 cycles after out_valid → sum=16 stable every cycle, out_valid stays 1, in_ready stays 0; after out_ready=1 for one edge, out_valid=0 and in_ready=1 the next cycle.
- WIDTH=8, start a=170, b=85, assert rst for 1 cycle at the 3rd ADD cycle → no out_valid ever for this operation; in_ready=1 after reset. Then a=1, b=2 → sum=3, carry_out=0 with normal latency.
- WIDTH=1 instance: a=1, b=1 → sum=0, carry_out=1 two cycles after the accept cycle. a=0, b=1 → sum=1, carry_out=0.
- WIDTH=8, in_valid held high continuously with a=10, b=20 and out_ready=1 → one accept per 10 cycles, each result sum=30; no accept while busy.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// The FSM states and the bit-counter width live here.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter must be able to hold WIDTH itself.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-add slice.
// The serial adder reuses this slice on every ADD cycle.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock, with
// valid/ready handshakes on the operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             fa_s, fa_c;

  full_adder_bit u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
          count_d = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        // New sum bit enters at the MSB; after WIDTH
        // shifts the LSB-first stream lands in place.
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
        carry_d          = fa_c;
        count_d          = count_q + CW'(1);
        if (count_q == LAST) begin
          cout_d      = fa_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder, WIDTH=8 and WIDTH=1.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic       out_valid, out_ready;
  logic [7:0] sum;
  logic       carry_out;

  logic       w1_in_valid, w1_in_ready;
  logic [0:0] w1_a, w1_b;
  logic       w1_out_valid, w1_out_ready;
  logic [0:0] w1_sum;
  logic       w1_carry_out;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  serial_adder #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .a         (w1_a),
    .b         (w1_b),
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .sum       (w1_sum),
    .carry_out (w1_carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full WIDTH=8 transaction with out_ready=1; latency counted
  // in edges from the accept edge (accept edge = 1).
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb,
                         input logic [7:0] es, input logic ec,
                         input string nm);
    int  lat;
    bit  busy_bad;
    a = ta; b = tb; in_valid = 1'b1; out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: in_ready=%b want 1", nm, in_ready);
    end
    step();
    in_valid = 1'b0;
    lat = 1;
    busy_bad = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      if (in_ready !== 1'b0) busy_bad = 1;
      step();
      lat++;
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy_ready: in_ready=1 during op want 0", nm);
    end
    checks++;
    if (lat != 9 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d (out_valid=%b) want 9", nm, lat, out_valid);
    end
    checks++;
    if (sum !== es || carry_out !== ec) begin
      errors++;
      $display("FAIL %s result: sum=%0d c=%b want sum=%0d c=%b", nm, sum, carry_out, es, ec);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'd0 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: ov=%b sum=%0d c=%b want 0/0/0", out_valid, sum, carry_out);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_in_rst: in_ready=%b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || w1_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: in_ready=%b w1=%b want 1/1", in_ready, w1_in_ready);
    end
  endtask

  task automatic test_basic();
    run_op8(8'd3, 8'd5, 8'd8, 1'b0, "add_3_5");
  endtask

  task automatic test_carry();
    run_op8(8'd200, 8'd100, 8'd44, 1'b1, "add_200_100");
    run_op8(8'd255, 8'd1, 8'd0, 1'b1, "wrap_255_1");
    run_op8(8'd255, 8'd255, 8'd254, 1'b1, "add_255_255");
  endtask

  task automatic test_backpressure();
    int  lat;
    bit  bad;
    a = 8'd7; b = 8'd9; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid: out_valid never rose (edges=%0d) want 9", lat);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (sum !== 8'd16 || carry_out !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        bad = 1;
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: sum=%0d ov=%b ir=%b want 16/1/0 held", sum, out_valid, in_ready);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: ov=%b ir=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_add();
    bit bad;
    a = 8'd170; b = 8'd85; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_rst: ov=%b ir=%b want 0/0", out_valid, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: in_ready=%b want 1", in_ready);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1;
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst_quiet: ov=%b ir=%b want 0/1 throughout", out_valid, in_ready);
    end
    run_op8(8'd1, 8'd2, 8'd3, 1'b0, "after_rst_1_2");
  endtask

  task automatic test_width1();
    int lat;
    logic [0:0] av [2] = '{1'b1, 1'b0};
    logic [0:0] bv [2] = '{1'b1, 1'b1};
    logic [0:0] es [2] = '{1'b0, 1'b1};
    logic       ec [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      w1_a = av[k]; w1_b = bv[k];
      w1_in_valid = 1'b1; w1_out_ready = 1'b1;
      step();
      w1_in_valid = 1'b0;
      lat = 1;
      while (w1_out_valid !== 1'b1 && lat < 10) begin
        step();
        lat++;
      end
      checks++;
      if (lat != 2 || w1_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL w1_latency_%0d: got %0d want 2", k, lat);
      end
      checks++;
      if (w1_sum !== es[k] || w1_carry_out !== ec[k]) begin
        errors++;
        $display("FAIL w1_result_%0d: sum=%b c=%b want %b/%b",
                 k, w1_sum, w1_carry_out, es[k], ec[k]);
      end
      step();
      checks++;
      if (w1_out_valid !== 1'b0 || w1_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL w1_release_%0d: ov=%b ir=%b want 0/1", k, w1_out_valid, w1_in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_acc, n_out, last_acc;
    bit gap_bad, sum_bad;
    a = 8'd10; b = 8'd20; in_valid = 1'b1; out_ready = 1'b1;
    n_acc = 0; n_out = 0; last_acc = -10;
    gap_bad = 0; sum_bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_ready === 1'b1) begin
        if (i - last_acc != 10) gap_bad = 1;
        last_acc = i;
        n_acc++;
      end
      if (out_valid === 1'b1) begin
        n_out++;
        if (sum !== 8'd30 || carry_out !== 1'b0) sum_bad = 1;
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (n_acc != 3 || gap_bad) begin
      errors++;
      $display("FAIL b2b_accepts: n=%0d gap_bad=%0b want 3 spaced 10", n_acc, gap_bad);
    end
    checks++;
    if (n_out != 3 || sum_bad) begin
      errors++;
      $display("FAIL b2b_results: n=%0d sum_bad=%0b want 3 of sum 30", n_out, sum_bad);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: ov=%b ir=%b want 0/1", out_valid, in_ready);
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    w1_in_valid = 1'b0; w1_out_ready = 1'b0; w1_a = '0; w1_b = '0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid_add();
    test_width1();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
